// File: rtl/sac_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
//   sac_state_t   : controller FSM state encoding
//   SAC_N_DEFAULT : default operand width / iteration count
package sac_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} sac_state_t;

  localparam int unsigned SAC_N_DEFAULT = 4;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the shift-and-add controller.
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset, clears the count
//   clear    : synchronous clear to zero (has priority over enable)
//   enable   : count up by one per cycle, saturating at N-1
//   terminal : high while the count equals N-1
module iter_counter #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count_q;

  assign terminal = (count_q == CNT_W'(N - 1));

  // Saturate at N-1 so the count can never wrap, even if enable is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !terminal) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_add_controller.sv
// Control FSM for a shift-and-add multiplier datapath (adder + C/A/Q register).
// Loads the operands, runs N add/shift iterations steered by Q0, then signals
// completion through a start/ready handshake. Holds no datapath bits.
// Optional feature: define SAC_ABORT_EN to add the abort input.
// Ports:
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : multiply request (level), accepted in IDLE
//   Q0        : LSB of the Q register, steers each EXEC iteration
//   abort     : (SAC_ABORT_EN only) cancel an operation in LOAD/EXEC
//   load      : strobe A<=0, C<=0, Q<=Qin
//   add_shift : strobe {C,A}<=A+M then shift {C,A,Q} right
//   shift     : strobe shift {C,A,Q} right
//   ready     : high when idle or result valid
//   done      : one-cycle pulse on entry to DONE
module shift_add_controller
  import sac_pkg::*;
#(
  parameter int unsigned N = SAC_N_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic Q0,
`ifdef SAC_ABORT_EN
  input  logic abort,
`endif
  output logic load,
  output logic add_shift,
  output logic shift,
  output logic ready,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  sac_state_t state_q, state_d;
  logic       done_q, done_d;
  logic       cnt_clear, cnt_enable, cnt_terminal;
  logic       abort_req;

`ifdef SAC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    add_shift  = 1'b0;
    shift      = 1'b0;
    ready      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        cnt_clear = 1'b1;
        state_d   = abort_req ? IDLE : EXEC;
      end
      EXEC: begin
        add_shift  = Q0;
        shift      = !Q0;
        cnt_enable = 1'b1;
        // Abort beats the final iteration.
        if (abort_req)         state_d = IDLE;
        else if (cnt_terminal) state_d = DONE;
      end
      DONE: begin
        ready = 1'b1;
        // Held start does not restart; it must drop first.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so the pulse comes from state, not from inputs.
    done_d = (state_q == EXEC) && (state_d == DONE);
  end

  assign done = done_q;

endmodule
